// File: rtl/ped_pkg.sv
// rtl/ped_pkg.sv - shared types and default parameters for the pedestrian request unit
package ped_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        SERVING = 2'b10,
        HOLDOFF = 2'b11
    } ped_state_t;

    localparam int TICK_DIV_DEF      = 1000;
    localparam int DB_CYCLES_DEF     = 16;
    localparam int HOLDOFF_TICKS_DEF = 8;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchroniser, debouncer and debounced rising-edge pulse
module btn_debounce
    import ped_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic db,
    output logic press_evt
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q;
    logic          btn_s_q;
    logic          db_q, db_d;
    logic          db_dly_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronised level disagrees with db,
    // so any disagreement shorter than DB_CYCLES samples is forgotten.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (btn_s_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = ~db_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            btn_s_q  <= 1'b0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_raw;
            btn_s_q  <= sync1_q;
            db_q     <= db_d;
            db_dly_q <= db_q;
            cnt_q    <= cnt_d;
        end
    end

    assign db        = db_q;
    assign press_evt = db_q & ~db_dly_q;

endmodule

// File: rtl/ped_request_unit.sv
// rtl/ped_request_unit.sv - pedestrian request latch, hold-off timer and phase tick prescaler
module ped_request_unit
    import ped_pkg::*;
#(
    parameter int TICK_DIV      = TICK_DIV_DEF,
    parameter int DB_CYCLES     = DB_CYCLES_DEF,
    parameter int HOLDOFF_TICKS = HOLDOFF_TICKS_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    input  logic cross_grant,
    output logic tick,
    output logic ped_req,
    output logic walk_lamp,
    output logic busy
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int HW = $clog2(HOLDOFF_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HO_LOAD   = HW'(HOLDOFF_TICKS);
    localparam logic [HW-1:0] HO_ONE    = HW'(1);

    logic          db_lvl;
    logic          press_evt;
    logic          press_ok;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [HW-1:0] ho_cnt_q;
    ped_state_t    state_q;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_raw   (btn_raw),
        .db        (db_lvl),
        .press_evt (press_evt)
    );

    // press_evt is only ever asserted while the debounced level is high
    assign press_ok = press_evt & db_lvl;

    assign tick       = (tick_cnt_q == TICK_LAST);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // Presses outside IDLE are dropped rather than queued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ho_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (press_ok) state_q <= ARMED;
                end
                ARMED: begin
                    if (cross_grant) state_q <= SERVING;
                end
                SERVING: begin
                    if (!cross_grant) begin
                        state_q  <= HOLDOFF;
                        ho_cnt_q <= HO_LOAD;
                    end
                end
                HOLDOFF: begin
                    if (tick) begin
                        ho_cnt_q <= ho_cnt_q - 1'b1;
                        if (ho_cnt_q == HO_ONE) state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign ped_req   = (state_q == ARMED);
    assign walk_lamp = (state_q == SERVING);
    assign busy      = (state_q != IDLE);

endmodule
